// File: rtl/axi4_lite_cmd_master.sv
// axi4_lite_cmd_master: single-outstanding AXI4-Lite master driven by a command/response stream
// Define AXI4_LITE_CMD_MASTER_ERR_CNT_EN to add the saturating err_count output.
module axi4_lite_cmd_master #(
  parameter int A = 32,
  parameter int N = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_write,
  input  logic [A-1:0]   cmd_addr,
  input  logic [N*8-1:0] cmd_wdata,
  input  logic [N-1:0]   cmd_wstrb,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [N*8-1:0] rsp_rdata,
  output logic [1:0]     rsp_resp,
  output logic           rsp_write,
  output logic [A-1:0]   awaddr,
  output logic [2:0]     awprot,
  output logic           awvalid,
  input  logic           awready,
  output logic [N*8-1:0] wdata,
  output logic [N-1:0]   wstrb,
  output logic           wvalid,
  input  logic           wready,
  input  logic [1:0]     bresp,
  input  logic           bvalid,
  output logic           bready,
  output logic [A-1:0]   araddr,
  output logic [2:0]     arprot,
  output logic           arvalid,
  input  logic           arready,
  input  logic [N*8-1:0] rdata,
  input  logic [1:0]     rresp,
  input  logic           rvalid,
  output logic           rready
`ifdef AXI4_LITE_CMD_MASTER_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WR_REQ = 3'd1;
  localparam logic [2:0] WR_RSP = 3'd2;
  localparam logic [2:0] RD_REQ = 3'd3;
  localparam logic [2:0] RD_RSP = 3'd4;
  localparam logic [2:0] RSP    = 3'd5;
  logic [2:0] state;
  assign cmd_ready = state == IDLE;
  assign awprot = 3'b000;
  assign arprot = 3'b000;
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      awvalid <= 1'b0;
      wvalid <= 1'b0;
      arvalid <= 1'b0;
      bready <= 1'b0;
      rready <= 1'b0;
      rsp_valid <= 1'b0;
      awaddr <= '0;
      araddr <= '0;
      wdata <= '0;
      wstrb <= '0;
      rsp_rdata <= '0;
      rsp_resp <= 2'b00;
      rsp_write <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          awaddr <= cmd_addr;
          araddr <= cmd_addr;
          wdata <= cmd_wdata;
          wstrb <= cmd_wstrb;
          rsp_write <= cmd_write;
          awvalid <= cmd_write;
          wvalid <= cmd_write;
          arvalid <= ~cmd_write;
          state <= cmd_write ? WR_REQ : RD_REQ;
        end
        WR_REQ: begin
          // AW and W retire independently; a dropped valid counts as done
          awvalid <= awvalid & ~awready;
          wvalid <= wvalid & ~wready;
          if ((~awvalid | awready) && (~wvalid | wready)) begin
            bready <= 1'b1;
            state <= WR_RSP;
          end
        end
        WR_RSP: if (bvalid) begin
          rsp_resp <= bresp;
          rsp_rdata <= '0;
          bready <= 1'b0;
          rsp_valid <= 1'b1;
          state <= RSP;
        end
        RD_REQ: if (arready) begin
          arvalid <= 1'b0;
          rready <= 1'b1;
          state <= RD_RSP;
        end
        RD_RSP: if (rvalid) begin
          rsp_rdata <= rdata;
          rsp_resp <= rresp;
          rready <= 1'b0;
          rsp_valid <= 1'b1;
          state <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef AXI4_LITE_CMD_MASTER_ERR_CNT_EN
  logic       cap;
  logic [1:0] cap_resp;
  always_comb begin
    cap = (state == WR_RSP && bvalid) || (state == RD_RSP && rvalid);
    cap_resp = state == WR_RSP ? bresp : rresp;
  end
  always_ff @(posedge aclk) begin
    if (areset) err_count <= '0;
    else if (cap && cap_resp != 2'b00 && ~&err_count) err_count <= err_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// tb_axi4_lite_cmd_master: directed and randomized checks of the command master against a
// behavioural slave and a word-level reference memory.
module tb_axi4_lite_cmd_master;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0] cmd_wstrb = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
`ifdef AXI4_LITE_CMD_MASTER_ERR_CNT_EN
  logic [1:0] err_count;
`endif

  always #5 aclk = ~aclk;

`ifdef AXI4_LITE_CMD_MASTER_ERR_CNT_EN
  axi4_lite_cmd_master #(.A(32), .N(4), .ERR_CNT_W(2)) dut (
`else
  axi4_lite_cmd_master #(.A(32), .N(4)) dut (
`endif
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
`ifdef AXI4_LITE_CMD_MASTER_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  // Behavioural slave: per-channel ready/valid delays, SLVERR injection, 16-word memory
  logic [31:0] smem [16];
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic err_en = 1'b0, spur = 1'b0;
  int aw_c, w_c, b_c, ar_c, r_c;
  logic aw_got, w_got, b_pend, r_pend;
  logic [31:0] aw_a, w_d, r_d, sa, sd;
  logic [3:0] w_s, ss;

  assign awready = awvalid && !aw_got && aw_c >= aw_dly;
  assign wready = wvalid && !w_got && w_c >= w_dly;
  assign arready = arvalid && !r_pend && ar_c >= ar_dly;
  assign bvalid = (b_pend && b_c >= b_dly) || spur;
  assign rvalid = (r_pend && r_c >= r_dly) || spur;
  assign bresp = err_en ? 2'b10 : 2'b00;
  assign rresp = err_en ? 2'b10 : 2'b00;
  assign rdata = r_d;

  always @(posedge aclk) begin
    if (areset) begin
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_c <= 0; w_c <= 0; b_c <= 0; ar_c <= 0; r_c <= 0; r_d <= '0;
    end else begin
      aw_c <= (awvalid && !awready) ? aw_c + 1 : 0;
      w_c <= (wvalid && !wready) ? w_c + 1 : 0;
      ar_c <= (arvalid && !arready) ? ar_c + 1 : 0;
      sa = aw_got ? aw_a : awaddr;
      sd = w_got ? w_d : wdata;
      ss = w_got ? w_s : wstrb;
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        if (!err_en)
          for (int i = 0; i < 4; i++) if (ss[i]) smem[sa[5:2]][8*i +: 8] <= sd[8*i +: 8];
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1;
      end else begin
        if (awvalid && awready) begin aw_got <= 1'b1; aw_a <= awaddr; end
        if (wvalid && wready) begin w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; end
      end
      b_c <= (b_pend && !(bvalid && bready)) ? b_c + 1 : 0;
      if (b_pend && bvalid && bready) b_pend <= 1'b0;
      if (arvalid && arready) begin r_pend <= 1'b1; r_d <= smem[araddr[5:2]]; end
      r_c <= (r_pend && !(rvalid && rready)) ? r_c + 1 : 0;
      if (r_pend && rvalid && rready) r_pend <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  logic [31:0] mdl [16];
  int errs = 0;
  bit [63:0] h_awv, h_wv, h_arv, h_brd, h_rrd;
  int rsp_cyc, acc_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command end to end; response fields checked against the reference memory
  task automatic run(input logic w, input logic [31:0] addr, input logic [31:0] d,
                     input logic [3:0] s, input int hold, input logic err);
    logic [31:0] erd;
    logic [1:0] ers;
    err_en = err;
    erd = w ? 32'h0 : mdl[addr[5:2]];
    ers = err ? 2'b10 : 2'b00;
    @(negedge aclk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = addr; cmd_wdata = d; cmd_wstrb = s;
    acc_cyc = cyc;
    @(posedge aclk);
    #1 cmd_valid = 1'b0;
    h_awv = '0; h_wv = '0; h_arv = '0; h_brd = '0; h_rrd = '0; rsp_cyc = 0;
    for (int k = 1; k < 64; k++) begin
      @(negedge aclk);
      h_awv[k] = awvalid; h_wv[k] = wvalid; h_arv[k] = arvalid;
      h_brd[k] = bready; h_rrd[k] = rready;
      if (rsp_valid) begin
        if (rsp_cyc == 0) begin
          rsp_cyc = k;
          chk("rsp_rdata", rsp_rdata, erd);
          chk("rsp_resp", rsp_resp, ers);
          chk("rsp_write", rsp_write, w);
        end else begin
          chk("rsp_rdata_stable", rsp_rdata, erd);
          chk("cmd_ready_busy", cmd_ready, 0);
        end
        if (hold > 0) hold--;
        else begin
          rsp_ready = 1'b1;
          @(posedge aclk);
          #1 rsp_ready = 1'b0;
          break;
        end
      end
    end
    if (rsp_cyc == 0) chk("rsp_timeout", rsp_valid, 1);
    if (w && !err)
      for (int i = 0; i < 4; i++) if (s[i]) mdl[addr[5:2]][8*i +: 8] = d[8*i +: 8];
    if (err) errs++;
`ifdef AXI4_LITE_CMD_MASTER_ERR_CNT_EN
    chk("err_count", err_count, errs > 3 ? 3 : errs);
`endif
  endtask

  initial begin
    int a1;
    bit got;
    for (int i = 0; i < 16; i++) begin smem[i] = '0; mdl[i] = '0; end
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {awvalid, wvalid, arvalid, rsp_valid}, 0);
    chk("rst_readys", {bready, rready}, 0);
    chk("rst_addr", {awaddr, araddr}, 0);
    chk("rst_wdata", {wdata, wstrb}, 0);
    chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_write}, 0);
    chk("prot_tied", {awprot, arprot}, 0);
`ifdef AXI4_LITE_CMD_MASTER_ERR_CNT_EN
    chk("rst_err_count", err_count, 0);
`endif

    // Stray B/R valids while idle must be ignored
    spur = 1'b1;
    repeat (2) begin
      @(negedge aclk);
      chk("spur_idle", {cmd_ready, rsp_valid, bready, rready}, 4'b1000);
    end
    spur = 1'b0;

    run(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    chk("wr_aw_w_c1", {h_awv[1], h_wv[1]}, 2'b11);
    chk("wr_bready_c2", h_brd[2], 1);
    chk("wr_rsp_c3", rsp_cyc, 3);
    chk("regfile_word2", smem[2], 32'hDEADBEEF);

    aw_dly = 3;
    run(1'b1, 32'h10, 32'h12345678, 4'hF, 0, 1'b0);
    aw_dly = 0;
    chk("wfirst_wvalid", {h_wv[2], h_wv[1]}, 2'b01);
    chk("wfirst_awvalid", {h_awv[5], h_awv[4], h_awv[3], h_awv[2], h_awv[1]}, 5'b01111);
    chk("wfirst_bready", {h_brd[5], h_brd[4]}, 2'b10);

    run(1'b0, 32'h8, 32'h0, 4'h0, 5, 1'b0);
    chk("rd_rready_c2", h_rrd[2], 1);
    chk("rd_arvalid_c1", {h_arv[2], h_arv[1], h_awv[1]}, 3'b010);

    run(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    a1 = acc_cyc;
    run(1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0);
    chk("cmd_spacing", acc_cyc - a1, 4);

    // Abandon a write stuck waiting for B
    b_dly = 6;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'b0011;
    @(posedge aclk);
    #1 cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge aclk); got = bready; end
    chk("reached_wr_rsp", bready, 1);
    areset = 1'b1;
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("mid_rst_valids", {awvalid, wvalid, arvalid, rsp_valid, bready, rready}, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_regs", {awaddr, wdata, rsp_rdata, rsp_resp, rsp_write}, 0);
    b_dly = 0;
    mdl[8][15:0] = 16'hF00D;
    errs = 0;
    run(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);

    run(1'b1, 32'h4, 32'h11111111, 4'hF, 0, 1'b1);
    run(1'b1, 32'h4, 32'h22222222, 4'hF, 0, 1'b0);
    run(1'b1, 32'hC, 32'h33333333, 4'hF, 1, 1'b1);
    run(1'b1, 32'h18, 32'h44444444, 4'hF, 0, 1'b1);
`ifdef AXI4_LITE_CMD_MASTER_ERR_CNT_EN
    chk("err_count_three", err_count, 3);
`endif
    run(1'b1, 32'h1C, 32'h55555555, 4'hF, 0, 1'b1);
    run(1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b1);
`ifdef AXI4_LITE_CMD_MASTER_ERR_CNT_EN
    chk("err_count_sat", err_count, 3);
`endif

    for (int t = 0; t < 40; t++) begin
      logic w;
      w = 1'($urandom_range(0, 1));
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      run(w, {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 2), $urandom_range(0, 4) == 0);
      chk("rand_req_c1", {h_awv[1], h_wv[1], h_arv[1]}, {w, w, ~w});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4_lite_cmd_master.md
# axi4_lite_cmd_master

Single-outstanding AXI4-Lite master that turns a simple command/response stream into AXI4-Lite write and read transactions. It sits directly upstream of `axi4_lite_register_file`: a CPU bridge, a test sequencer or a config loader issues commands here, and the AXI4-Lite side drives the register file's slave port. Exactly one transaction is in flight at a time. Every AXI output is registered.

## Interface
Parameters:
- `A`, 32, address width in bits.
- `N`, 4, data width in bytes (4 or 8); data width is N*8.
- `ERR_CNT_W`, 8, width of the error counter (used only when the Configuration macro is defined).

Ports:
- `aclk`  in  1  clock; all logic on the rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  A  byte address.
- `cmd_wdata`  in  N*8  write data.
- `cmd_wstrb`  in  N  write strobes.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response accepted.
- `rsp_rdata`  out  N*8  read data; 0 for writes.
- `rsp_resp`  out  2  BRESP or RRESP as received.
- `rsp_write`  out  1  echoes `cmd_write`.
- `awaddr` / `awprot` / `awvalid`  out  A / 3 / 1  AW channel; `awprot` is tied to 0.
- `awready`  in  1
- `wdata` / `wstrb` / `wvalid`  out  N*8 / N / 1  W channel.
- `wready`  in  1
- `bresp` / `bvalid`  in  2 / 1
- `bready`  out  1
- `araddr` / `arprot` / `arvalid`  out  A / 3 / 1  AR channel; `arprot` is tied to 0.
- `arready`  in  1
- `rdata` / `rresp` / `rvalid`  in  N*8 / 2 / 1
- `rready`  out  1
- `err_count`  out  ERR_CNT_W  present only when the Configuration macro is defined.

## Operation
- States are IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP and RSP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch addr, wdata, wstrb and write.
  - Go to WR_REQ with `awvalid`=`wvalid`=1, or to RD_REQ with `arvalid`=1.
- WR_REQ:
  - AW and W complete independently.
  - `awvalid` drops the cycle after `awvalid & awready`; `wvalid` drops the cycle after `wvalid & wready`.
  - Both may complete in the same cycle, or in either order.
  - Once both are done, go to WR_RSP with `bready`=1.
- WR_RSP: on `bvalid`, capture `bresp` into `rsp_resp`, set `rsp_rdata`=0, drop `bready`, go to RSP.
- RD_REQ: on `arvalid & arready`, drop `arvalid`, set `rready`=1, go to RD_RSP.
- RD_RSP: on `rvalid`, capture `rdata` and `rresp`, drop `rready`, go to RSP.
- RSP:
  - `rsp_valid`=1, with data held stable until `rsp_ready`.
  - On `rsp_ready`, return to IDLE and clear `rsp_valid`.
- The block never asserts a valid before the corresponding command is latched. Once a valid is asserted, it is never deasserted before its handshake.
- `bvalid` or `rvalid` arriving outside WR_RSP or RD_RSP is ignored; `bready` and `rready` are 0 in those states.

## Timing
- Reset values:
  - State IDLE.
  - All `*valid` and `*ready` outputs 0, except `cmd_ready`=1.
  - `awaddr`, `araddr`, `wdata`, `wstrb`, `rsp_rdata` and `rsp_resp` = 0.
  - `rsp_write`=0, `err_count`=0.
- Reset asserted mid-transaction abandons it; all outputs take reset values at the next edge.
- Command accepted at edge 0:
  - `aw/wvalid` or `arvalid` are high in cycle 1.
  - With a zero-wait slave, `bready` or `rready` are high in cycle 2.
  - `rsp_valid` is high in cycle 3.
- Minimum command-to-command spacing is 4 cycles when `rsp_ready` is held at 1.
- `cmd_ready` is decoded from the state register only; it has no combinational path from `cmd_valid`.

## Configuration
- `AXI4_LITE_CMD_MASTER_ERR_CNT_EN`:
  - When defined, `err_count` exists.
  - It increments by 1 when a response with `rsp_resp`≠2'b00 is captured into RSP, and saturates at all-ones.
  - It is cleared only by `areset`.
- When undefined, the port and counter are absent; all other behaviour is identical.

## Test plan
- Write with a zero-wait slave: addr 0x8, data 0xDEADBEEF, strb 0xF.
  - Required: `awvalid`/`wvalid` in cycle 1, `rsp_valid` in cycle 3, `rsp_resp`=0, register 2 of the downstream register file = 0xDEADBEEF.
- W before AW: `wready`=1 at cycle 1, `awready` delayed to cycle 4.
  - Required: `wvalid` drops in cycle 2, `awvalid` held until cycle 4, `bready` high in cycle 5.
- Read 0x8 after the write, with `rsp_ready` held low for 5 cycles.
  - Required: `rsp_rdata`=0xDEADBEEF held stable throughout, and `cmd_ready`=0 until the response is accepted.
- `areset` asserted while in WR_RSP.
  - Required: next cycle all valids and readys are 0, `cmd_ready`=1, and a following read completes normally.
- Slave returns SLVERR (2'b10) on 3 writes and OKAY on 1.
  - Required: `rsp_resp`=2'b10 on each failing write, and `err_count`=3 with the macro defined.
  - With `ERR_CNT_W`=2, 5 errors give `err_count`=3 (saturated).
